// File: rtl/surf_arb_pkg.sv
// Shared types and constants for the SURF readout arbiter.
// State encoding, header nibble and tuser field positions.
package surf_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_XFER  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  localparam int SRC_W       = 3;
  localparam int TUSER_W     = 4;
  localparam int TUSER_SRC   = 0;
  localparam int TUSER_ABORT = 3;

endpackage

// File: rtl/surf_readout_arbiter_rr_grant.sv
// Round-robin priority picker: first set request above the pointer.
// Purely combinational, reusable by other rackbus arbiters.
module rr_grant #(
  parameter int N  = 7,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          valid
);

  // Scan upward from ptr+1 with wrap; the first hit wins.
  always_comb begin
    int cand;
    idx    = '0;
    onehot = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        idx          = IW'(cand);
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/surf_readout_arbiter.sv
// Packet round-robin merge of SURF readout streams with stall watchdog.
// Optional header beat per packet when SURF_ARB_HDR_EN is defined.
module surf_readout_arbiter
  import surf_arb_pkg::*;
#(
  parameter int         NSURF       = 7,
  parameter int         STALL_LIMIT = 1023,
  parameter int         STALL_BITS  = 10,
  parameter logic [7:0] ABORT_BYTE  = 8'hFF
) (
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic [8*NSURF-1:0]   s_tdata,
  input  logic [NSURF-1:0]     s_tvalid,
  input  logic [NSURF-1:0]     s_tlast,
  output logic [NSURF-1:0]     s_tready,
  input  logic [NSURF-1:0]     enable_i,
  input  logic                 clear_i,
  output logic [7:0]           m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic [TUSER_W-1:0]   m_tuser,
  input  logic                 m_tready,
  output logic [NSURF-1:0]     quarantine_o,
  output logic [15:0]          pkt_count_o
);

  localparam logic [SRC_W-1:0] PTR_RST =
    SRC_W'(NSURF - 1);
  localparam logic [STALL_BITS-1:0] STALL_MAX =
    STALL_BITS'(STALL_LIMIT);

`ifdef SURF_ARB_HDR_EN
  localparam arb_state_t FIRST_ST = ST_HDR;
`else
  localparam arb_state_t FIRST_ST = ST_XFER;
`endif

  arb_state_t state;
  arb_state_t state_nxt;

  logic [SRC_W-1:0]      grant;
  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      pick;
  logic [NSURF-1:0]      grant_oh;
  logic [NSURF-1:0]      pick_oh;
  logic [NSURF-1:0]      req;
  logic [NSURF-1:0]      quarantine;
  logic [NSURF-1:0]      quar_nxt;
  logic                  pick_vld;
  logic [STALL_BITS-1:0] stall_cnt;
  logic [15:0]           pkt_count;

  logic [7:0] g_data;
  logic       g_valid;
  logic       g_last;
  logic       xfer_done;
  logic       stall_hit;
  logic       abort_done;
  logic       take_grant;

  assign req = s_tvalid & enable_i & ~quarantine;

  rr_grant #(
    .N  (NSURF),
    .IW (SRC_W)
  ) u_rr (
    .req    (req),
    .ptr    (rr_ptr),
    .idx    (pick),
    .onehot (pick_oh),
    .valid  (pick_vld)
  );

  // Select the granted source's stream signals.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NSURF; i++) begin
      if (grant_oh[i]) begin
        g_data  = s_tdata[8*i +: 8];
        g_valid = s_tvalid[i];
        g_last  = s_tlast[i];
      end
    end
  end

  assign take_grant = (state == ST_IDLE) & pick_vld;
  assign xfer_done  = (state == ST_XFER) & g_valid
                    & m_tready & g_last;
  assign stall_hit  = (state == ST_XFER) & ~g_valid
                    & (stall_cnt == STALL_MAX);
  assign abort_done = (state == ST_ABORT) & m_tready;

  // A quarantine set in the same cycle as clear must survive.
  always_comb begin
    quar_nxt = clear_i ? '0 : quarantine;
    if (abort_done) begin
      quar_nxt = quar_nxt | grant_oh;
    end
  end

  // State register.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_vld) state_nxt = FIRST_ST;
      end
      ST_HDR: begin
        if (m_tready) state_nxt = ST_XFER;
      end
      ST_XFER: begin
        if (xfer_done) begin
          state_nxt = ST_IDLE;
        end else if (stall_hit) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (abort_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant, pointer, watchdog, quarantine and packet counter.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant      <= '0;
      grant_oh   <= '0;
      rr_ptr     <= PTR_RST;
      stall_cnt  <= '0;
      quarantine <= '0;
      pkt_count  <= '0;
    end else begin
      if (take_grant) begin
        grant    <= pick;
        grant_oh <= pick_oh;
        rr_ptr   <= pick;
      end
      if (state == ST_XFER) begin
        if (g_valid) begin
          stall_cnt <= '0;
        end else if (stall_cnt != STALL_MAX) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        stall_cnt <= '0;
      end
      quarantine <= quar_nxt;
      if (xfer_done) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  // Output drive per state; IDLE presents an all-zero bus.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    m_tuser  = '0;
    s_tready = '0;
    case (state)
      ST_HDR: begin
        m_tdata  = {HDR_NIBBLE, 1'b0, grant};
        m_tvalid = 1'b1;
        m_tuser  = {1'b0, grant};
      end
      ST_XFER: begin
        m_tdata  = g_data;
        m_tvalid = g_valid;
        m_tlast  = g_last;
        m_tuser  = {1'b0, grant};
        s_tready = grant_oh & {NSURF{m_tready}};
      end
      ST_ABORT: begin
        m_tdata  = ABORT_BYTE;
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = {1'b1, grant};
      end
      default: begin
        m_tvalid = 1'b0;
      end
    endcase
  end

  assign quarantine_o = quarantine;
  assign pkt_count_o  = pkt_count;

endmodule
